// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for inter-stage pipeline registers: decoded control bundle,
// pack/unpack helpers and the per-stage bubble (NOP) control values.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    RESULT_MEM = 2'b00,
    RESULT_ALU = 2'b01,
    RESULT_PC4 = 2'b10
  } result_sel_t;

  typedef struct packed {
    logic        reg_w;
    logic        mem_w;
    result_sel_t result_sel;
    logic [1:0]  alu_src;
    logic        branch;
    logic        jump;
  } bundle_decode_t;

  localparam int CTRL_BUNDLE_W = $bits(bundle_decode_t);

  function automatic logic [CTRL_BUNDLE_W-1:0] pack_ctrl(input bundle_decode_t b);
    return b;
  endfunction

  function automatic bundle_decode_t unpack_ctrl(input logic [CTRL_BUNDLE_W-1:0] v);
    return bundle_decode_t'(v);
  endfunction

  // Bubbles never write registers or memory; later stages select the ALU result
  // so a bubble reaching writeback drives a harmless, defined mux select.
  localparam bundle_decode_t BUBBLE_ALU = '{
    reg_w: 1'b0, mem_w: 1'b0, result_sel: RESULT_ALU,
    alu_src: 2'b00, branch: 1'b0, jump: 1'b0
  };

  localparam logic [CTRL_BUNDLE_W-1:0] CTRL_BUBBLE_IFID  = '0;
  localparam logic [CTRL_BUNDLE_W-1:0] CTRL_BUBBLE_IDEX  = BUBBLE_ALU;
  localparam logic [CTRL_BUNDLE_W-1:0] CTRL_BUBBLE_EXMEM = BUBBLE_ALU;
  localparam logic [CTRL_BUNDLE_W-1:0] CTRL_BUBBLE_MEMWB = BUBBLE_ALU;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer: catches the word accepted while the output register
// is stalled, so the stage's ready can be a pure register.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full_reg <= 1'b0;
    end else if (push) begin
      full_reg <= 1'b1;
    end else if (pop) begin
      full_reg <= 1'b0;
    end

    if (reset) begin
      data_reg <= '0;
    end else if (push) begin
      data_reg <= din;
    end
  end

  assign dout = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready, flush-to-bubble and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for a registered ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W   = 32*4,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              xfer_in;
  logic              xfer_out;
  logic              stall;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [CTRL_W-1:0] load_ctrl;

  assign xfer_in  = valid_i && ready_o;
  assign xfer_out = valid_reg && ready_i;
  assign stall    = valid_reg && !ready_i;

`ifdef PIPE_STAGE_SKID_EN
  logic                     skid_full;
  logic                     skid_push;
  logic                     skid_pop;
  logic [DATA_W+CTRL_W-1:0] skid_dout;

  // Depends only on registered state, which breaks the ready_i->ready_o path.
  assign ready_o   = !reset && !skid_full;
  assign skid_push = xfer_in && stall;
  assign skid_pop  = skid_full && xfer_out;

  pipe_skid_buf #(
    .W(DATA_W + CTRL_W)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   ({data_i, ctrl_i}),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  // A pop and a direct load never coincide: a full skid holds ready_o low.
  assign load      = (xfer_in && !stall) || skid_pop;
  assign load_data = skid_pop ? skid_dout[DATA_W+CTRL_W-1:CTRL_W] : data_i;
  assign load_ctrl = skid_pop ? skid_dout[CTRL_W-1:0] : ctrl_i;
`else
  assign ready_o   = !reset && (ready_i || !valid_reg);
  assign load      = xfer_in;
  assign load_data = data_i;
  assign load_ctrl = ctrl_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= CTRL_RST;
      cnt_reg   <= '0;
    end else begin
      // Flush keeps data_reg: only valid and control need to become a bubble.
      if (flush_i) begin
        valid_reg <= 1'b0;
        ctrl_reg  <= CTRL_RST;
      end else if (load) begin
        valid_reg <= 1'b1;
        data_reg  <= load_data;
        ctrl_reg  <= load_ctrl;
      end else if (xfer_out) begin
        valid_reg <= 1'b0;
        ctrl_reg  <= CTRL_RST;
      end

      if (stall && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign valid_o     = valid_reg;
  assign data_o      = data_reg;
  assign ctrl_o      = ctrl_reg;
  assign stall_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, stall, flush,
// counter saturation, mid-stall reset and a random ordering run.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [7:0] BUB = 8'h10;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_i;
  logic         ready_i;
  logic         flush_i;
  logic [127:0] data_i;
  logic [7:0]   ctrl_i;

  logic         ready_o, valid_o;
  logic [127:0] data_o;
  logic [7:0]   ctrl_o;
  logic [15:0]  stall_cnt_o;

  logic         ready4, valid4;
  logic [127:0] data4;
  logic [7:0]   ctrl4;
  logic [3:0]   cnt4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(128), .CTRL_W(8), .CTRL_RST(CTRL_BUBBLE_IDEX), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .ctrl_i(ctrl_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_reg #(
    .DATA_W(128), .CTRL_W(8), .CTRL_RST(CTRL_BUBBLE_IDEX), .CNT_W(4)
  ) dut4 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready4),
    .data_i(data_i), .ctrl_i(ctrl_i), .flush_i(flush_i), .valid_o(valid4),
    .ready_i(ready_i), .data_o(data4), .ctrl_o(ctrl4), .stall_cnt_o(cnt4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sent;
    int unsigned rcvd;
    logic hold, in_acc, out_acc, r0;

    // 1: reset with valid_i asserted
    reset = 1'b1; valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
    data_i = 128'h55; ctrl_i = 8'hFF;
    step(); step();
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_ctrl", 128'(ctrl_o), 128'(BUB));
    chk("rst_data", data_o, 128'(0));
    chk("rst_cnt", 128'(stall_cnt_o), 128'(0));
    chk("rst_ready", 128'(ready_o), 128'(0));
    reset = 1'b0; valid_i = 1'b0;
    step();
    $display("reset: valid_o=%0d ctrl_o=%0h", valid_o, ctrl_o);

    // 2: streaming 0x10,0x20,0x30
    valid_i = 1'b1; data_i = 128'h10; ctrl_i = 8'h81;
    #1 chk("str_ready", 128'(ready_o), 128'(1));
    step();
    chk("str_d0", data_o, 128'h10); chk("str_v0", 128'(valid_o), 128'(1));
    chk("str_c0", 128'(ctrl_o), 128'h81);
    data_i = 128'h20; ctrl_i = 8'h82;
    step();
    chk("str_d1", data_o, 128'h20); chk("str_v1", 128'(valid_o), 128'(1));
    data_i = 128'h30; ctrl_i = 8'h83;
    step();
    chk("str_d2", data_o, 128'h30); chk("str_v2", 128'(valid_o), 128'(1));
    valid_i = 1'b0;
    step();
    chk("str_end_v", 128'(valid_o), 128'(0));
    chk("str_end_c", 128'(ctrl_o), 128'(BUB));
    chk("str_end_d", data_o, 128'h30);
    $display("stream: last data_o=%0h", data_o);

    // 3: stall with 0xAA held, 0xBB offered
    valid_i = 1'b1; data_i = 128'hAA; ctrl_i = 8'h84;
    step();
    chk("stl_load", data_o, 128'hAA);
    ready_i = 1'b0; data_i = 128'hBB; ctrl_i = 8'h85;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("stl_rdy_skid", 128'(ready_o), 128'(1));
    step();
    valid_i = 1'b0;
`else
    chk("stl_rdy_base", 128'(ready_o), 128'(0));
    step();
`endif
    step(); step(); step(); step();
    chk("stl_data", data_o, 128'hAA);
    chk("stl_valid", 128'(valid_o), 128'(1));
    chk("stl_cnt", 128'(stall_cnt_o), 128'(5));
    chk("stl_ready", 128'(ready_o), 128'(0));
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("stl_next", data_o, 128'hBB);
    chk("stl_next_c", 128'(ctrl_o), 128'h85);
    chk("stl_cnt_hold", 128'(stall_cnt_o), 128'(5));
    step();
    chk("stl_drain", 128'(valid_o), 128'(0));
    $display("stall: stall_cnt_o=%0d", stall_cnt_o);

    // 4: flush drops a same-cycle transfer in
    valid_i = 1'b1; data_i = 128'h11; ctrl_i = 8'h86;
    step();
    chk("fl_load", data_o, 128'h11);
    flush_i = 1'b1; data_i = 128'hCC; ctrl_i = 8'h87;
    #1 chk("fl_ready", 128'(ready_o), 128'(1));
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_valid", 128'(valid_o), 128'(0));
    chk("fl_ctrl", 128'(ctrl_o), 128'(BUB));
    chk("fl_data", data_o, 128'h11);
    step();
    chk("fl_after", data_o, 128'h11);
    chk("fl_after_v", 128'(valid_o), 128'(0));
    $display("flush: valid_o=%0d data_o=%0h", valid_o, data_o);

    // 5: saturation on the CNT_W=4 instance, then reset mid-stall
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat_rst", 128'(cnt4), 128'(0));
    valid_i = 1'b1; data_i = 128'h77; ctrl_i = 8'h88;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", 128'(cnt4), 128'(15));
    chk("sat_cnt16", 128'(stall_cnt_o), 128'(20));
    chk("sat_data", data_o, 128'h77);
    reset = 1'b1;
    step();
    reset = 1'b0; ready_i = 1'b1;
    chk("mid_rst_v", 128'(valid_o), 128'(0));
    chk("mid_rst_d", data_o, 128'(0));
    chk("mid_rst_c", 128'(ctrl_o), 128'(BUB));
    chk("mid_rst_cnt", 128'(stall_cnt_o), 128'(0));
    $display("saturation: cnt4=%0d", cnt4);

    // 6: random valid/ready, order and count preserved
    sent = 0; rcvd = 0; hold = 1'b0; ctrl_i = 8'h89;
    step();
    for (int c = 0; c < 1000; c++) begin
      r0 = ready_o;
      if (!hold) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = 128'(sent);
      end
      ready_i = ($urandom_range(0, 2) != 0);
      #1;
`ifdef PIPE_STAGE_SKID_EN
      chk("rdy_iso", 128'(ready_o), 128'(r0));
`endif
      in_acc  = valid_i && ready_o;
      out_acc = valid_o && ready_i;
      if (out_acc) begin
        chk("order", data_o, 128'(rcvd));
        rcvd++;
      end
      hold = valid_i && !in_acc;
      if (in_acc) sent++;
      step();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (valid_o) begin
        chk("order_drain", data_o, 128'(rcvd));
        rcvd++;
      end
      step();
    end
    chk("count", 128'(rcvd), 128'(sent));
    $display("random: sent=%0d received=%0d", sent, rcvd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
